// File: rtl/dmem_if.sv
// dmem_if: load/store port between the core's memory stage and the data memory.
//   Request channel  : req_valid/req_ready handshake carrying req_we, req_addr,
//                      req_wdata and req_wstrb.
//   Response channel : rsp_valid/rsp_ready handshake carrying rsp_rdata and rsp_err.
//   master : memory-stage side (drives requests, consumes responses).
//   slave  : responder side (accepts requests, produces responses).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the core's load/store port.
// Accepts one word request at a time, waits LATENCY cycles, then performs the
// load or byte-strobed store on internal word storage and returns the result.
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset (storage contents are not cleared)
//   bus  : dmem_if slave modport
//          req_valid/req_ready, req_we, req_addr (byte address), req_wdata, req_wstrb
//          rsp_valid/rsp_ready, rsp_rdata (0 for stores/errors), rsp_err
// Parameters:
//   ADDR_WIDTH : log2 of storage depth in 32-bit words
//   LATENCY    : wait cycles between accept and memory access (0..15)
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    RESET_EXIT,
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Misaligned or beyond the implemented word range.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
  endfunction

  state_t state;
  state_t state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       access;
  logic       accept;

  logic                  req_ready_p1;
  logic                  rsp_valid_p1;
  logic [31:0]           rsp_rdata_p1;
  logic                  rsp_err_p1;

  logic                  we_p0;
  logic [ADDR_WIDTH-1:0] idx_p0;
  logic [31:0]           wdata_p0;
  logic [3:0]            wstrb_p0;
  logic                  err_p0;

  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_wstrb;
  logic                  acc_err;

  logic [31:0] mem [DEPTH];

  assign accept = bus.req_valid & req_ready_p1;

  // Stage p0: request latched at accept; fields may change on the bus afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      idx_p0   <= bus.req_addr[ADDR_WIDTH+1:2];
      wdata_p0 <= bus.req_wdata;
      wstrb_p0 <= bus.req_wstrb;
      err_p0   <= addr_err(bus.req_addr);
    end
  end

  // With zero latency the access happens on the accept edge itself, so it must
  // use the live bus fields rather than the latched copy.
  always_comb begin
    acc_we    = we_p0;
    acc_idx   = idx_p0;
    acc_wdata = wdata_p0;
    acc_wstrb = wstrb_p0;
    acc_err   = err_p0;
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_idx   = bus.req_addr[ADDR_WIDTH+1:2];
      acc_wdata = bus.req_wdata;
      acc_wstrb = bus.req_wstrb;
      acc_err   = addr_err(bus.req_addr);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      RESET_EXIT: state_nxt = IDLE;
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nxt = RESP;
            access    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_valid_p1 && bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = RESET_EXIT;
    endcase
  end

  // Stage p1: control state and the registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RESET_EXIT;
      cnt          <= 4'd0;
      req_ready_p1 <= 1'b0;
      rsp_valid_p1 <= 1'b0;
      rsp_rdata_p1 <= 32'd0;
      rsp_err_p1   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      req_ready_p1 <= (state_nxt == IDLE);
      rsp_valid_p1 <= (state_nxt == RESP);
      if (access) begin
        rsp_err_p1   <= acc_err;
        rsp_rdata_p1 <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Storage is deliberately left out of reset. Reset forces the FSM out of
  // WAIT/IDLE, so an abandoned access can never reach this write.
  always_ff @(posedge clk) begin
    if (access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_p1;
  assign bus.rsp_valid = rsp_valid_p1;
  assign bus.rsp_rdata = rsp_rdata_p1;
  assign bus.rsp_err   = rsp_err_p1;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=2 and one with LATENCY=0
// share a single driver; sel picks which instance the stimulus addresses.
module tb_dmem_responder;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        rsp_ready = 1'b0;

  logic        req_ready_m;
  logic        rsp_valid_m;
  logic [31:0] rsp_rdata_m;
  logic        rsp_err_m;

  dmem_if bus_a ();
  dmem_if bus_b ();

  assign bus_a.req_valid = req_valid & ~sel;
  assign bus_b.req_valid = req_valid & sel;
  assign bus_a.req_we    = req_we;
  assign bus_b.req_we    = req_we;
  assign bus_a.req_addr  = req_addr;
  assign bus_b.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_b.req_wdata = req_wdata;
  assign bus_a.req_wstrb = req_wstrb;
  assign bus_b.req_wstrb = req_wstrb;
  assign bus_a.rsp_ready = rsp_ready & ~sel;
  assign bus_b.rsp_ready = rsp_ready & sel;

  assign req_ready_m = sel ? bus_b.req_ready : bus_a.req_ready;
  assign rsp_valid_m = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign rsp_rdata_m = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  assign rsp_err_m   = sel ? bus_b.rsp_err   : bus_a.rsp_err;

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  logic [31:0] model [int];
  bit hs_done = 1'b0;
  int hs_cyc  = 0;
  int last_acc = -1;

  // Response monitor: a valid&ready seen here completes on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid_m) begin
      if (sb_q.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_valid_m), 32'd0);
      end else if (rsp_ready) begin
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata_m, e.rdata);
        chk("rsp_err", 32'(rsp_err_m), 32'(e.err));
        hs_done = 1'b1;
        hs_cyc  = cyc + 1;
      end
    end
  end

  task automatic wait_accept(output int acc_edge, output bit ok);
    ok = 1'b0;
    acc_edge = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready_m) begin
        ok = 1'b1;
        acc_edge = cyc + 1;
        break;
      end
    end
  endtask

  // One complete transaction. hold>0 stalls the response for that many cycles
  // after rsp_valid appears; space>0 checks the accept-to-accept distance.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input int hold, input int space);
    exp_t e;
    int key;
    int acc_edge;
    int lat;
    bit ok;
    logic [31:0] v_d;
    logic v_e;
    lat = sel ? 0 : 2;
    key = (sel ? 1024 : 0) + int'(addr[AW+1:2]);
    e.err = (addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != 32'd0);
    e.rdata = 32'd0;
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (wstrb[i]) model[key][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        e.rdata = model.exists(key) ? model[key] : 32'd0;
      end
    end
    sb_q.push_back(e);
    hs_done   = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    rsp_ready = (hold == 0);
    wait_accept(acc_edge, ok);
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      void'(sb_q.pop_back());
      return;
    end
    if (space > 0 && last_acc >= 0) chk("req_spacing", 32'(acc_edge - last_acc), 32'(space));
    last_acc = acc_edge;
    @(posedge clk);
    #1;
    // Scramble the bus to show the request was latched at accept.
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1) != 0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom_range(0, 15));
    if (hold > 0) begin
      // A request presented while not ready must be ignored.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h40;
      req_wdata = 32'h0;
      req_wstrb = 4'hF;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (rsp_valid_m) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      if (!ok) chk("rsp_valid_timeout", 32'd0, 32'd1);
      v_d = rsp_rdata_m;
      v_e = rsp_err_m;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("bp_valid", 32'(rsp_valid_m), 32'd1);
        chk("bp_rdata", rsp_rdata_m, v_d);
        chk("bp_err", 32'(rsp_err_m), 32'(v_e));
        chk("bp_req_ready", 32'(req_ready_m), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      last_acc  = -1;
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (hs_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("rsp_valid_fall", 32'(rsp_valid_m), 32'd0);
    chk("req_ready_rise", 32'(req_ready_m), 32'd1);
    // rsp_valid is seen by the consumer at accept+LATENCY+1, so with
    // rsp_ready already high the handshake lands on that edge.
    if (hold == 0) chk("latency", 32'(hs_cyc - acc_edge), 32'(lat + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_edge;
    bit ok;
    logic [31:0] a;
    logic [31:0] d;

    // Reset: requests and response-ready are ignored while rst is high.
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus_a.rsp_err), 32'd0);
    chk("rst_b_req_ready", 32'(bus_b.req_ready), 32'd0);
    chk("rst_b_rsp_valid", 32'(bus_b.rsp_valid), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exit_ready_low", 32'(req_ready_m), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_exit_ready_high", 32'(req_ready_m), 32'd1);

    // LATENCY=2 instance.
    sel = 1'b0;
    xfer(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 0, 4);
    xfer(1'b1, 32'h40, 32'h00AA0000, 4'h4, 0, 4);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 0, 4);
    chk("merge_model", model[16], 32'hDEAABEEF);
    xfer(1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 0, 4);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 0, 4);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 5, 0);

    // Errors: misaligned load, out-of-range store that would alias word 0.
    xfer(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0);
    xfer(1'b0, 32'h42, 32'h0, 4'h0, 0, 4);
    xfer(1'b1, 32'h1000, 32'h0BADBAD0, 4'hF, 0, 4);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 4);
    xfer(1'b1, 32'hFFC, 32'h13579BDF, 4'h3, 0, 4);
    xfer(1'b0, 32'hFFC, 32'h0, 4'h0, 0, 4);

    // Reset one cycle after accepting a store: the store must be abandoned.
    xfer(1'b1, 32'h80, 32'h11111111, 4'hF, 0, 0);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h80;
    req_wdata = 32'h12345678;
    req_wstrb = 4'hF;
    wait_accept(acc_edge, ok);
    if (!ok) chk("abort_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_rst_valid", 32'(rsp_valid_m), 32'd0);
    chk("abort_rst_ready", 32'(req_ready_m), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_rsp", 32'(rsp_valid_m), 32'd0);
    end
    last_acc = -1;
    xfer(1'b0, 32'h80, 32'h0, 4'h0, 0, 0);
    chk("abort_model", model[32], 32'h11111111);

    // LATENCY=0 instance.
    sel = 1'b1;
    last_acc = -1;
    xfer(1'b1, 32'h10, 32'h55AA33CC, 4'hF, 0, 0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, 2);
    for (int i = 0; i < 6; i++) begin
      a = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      d = $urandom;
      xfer(1'b1, a, d, 4'($urandom_range(1, 15)), 0, 2);
      xfer(1'b0, a, 32'h0, 4'h0, 0, 2);
    end
    xfer(1'b1, 32'h10, 32'h0000FF00, 4'h2, 0, 2);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, 2);
    xfer(1'b0, 32'h11, 32'h0, 4'h0, 0, 2);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3, 0);

    // The LATENCY=2 instance's storage is independent of the other one.
    sel = 1'b0;
    last_acc = -1;
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 0);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
